hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL provide parameter REG_AW, 5, register-address width.
REQ-002 SHALL provide parameter DEPTH, 2, number of tracked in-flight writer stages (legal 1..4).
REQ-003 SHALL provide parameter LOAD_LAT, 1, stages during which a load result is not yet forwardable (legal 0..DEPTH-1).
REQ-004 SHALL derive local SW = clog2(DEPTH+1), the width of the forward-select codes.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk_i  input  1  clock; all state updates on the rising edge.
REQ-007 rst_n_i  input  1  asynchronous active-low reset.
REQ-008 issue_valid_i  input  1  the ID instruction advances to EX this cycle.
REQ-009 issue_rd_i  input  REG_AW  destination register of the issuing instruction.
REQ-010 issue_we_i  input  1  issuing instruction writes the register file.
REQ-011 issue_load_i  input  1  issuing instruction is a load.
REQ-012 flush_i  input  1  squash the issuing instruction.
REQ-013 id_rs_i, id_rt_i  input  REG_AW each  ID-stage source registers.
REQ-014 id_rs_used_i, id_rt_used_i  input  1 each  the source is actually read.
REQ-015 fwd_rs_o, fwd_rt_o  output  SW each  0 = register file; k = result of stage k (1 = youngest).
REQ-016 stall_o  output  1  load-use hazard; hold IF/ID and issue a bubble.
REQ-017 stall_cnt_o  output  16  saturating count of stall cycles.
REQ-018 fwd_cnt_o  output  16  saturating count of cycles with any nonzero forward code.

Function
REQ-019 SHALL keep a shift pipeline of DEPTH records {valid, rd, load}; record k is the instruction issued k cycles ago.
REQ-020 Each cycle, record k SHALL take record k-1 (k = 2..DEPTH); record DEPTH SHALL be discarded.
REQ-021 Record 1 SHALL capture {issue_we_i && issue_rd_i != 0, issue_rd_i, issue_load_i} when issue_valid_i=1, stall_o=0 and flush_i=0; otherwise it SHALL capture a bubble (valid=0).
REQ-022 flush_i SHALL take priority over issue_valid_i and SHALL NOT affect records 2..DEPTH.
REQ-023 For each source, the match SHALL be the smallest k with record k valid and rd equal to the source; the youngest match wins.
REQ-024 A match SHALL be hazardous when record k has load=1 and k <= LOAD_LAT.
REQ-025 fwd_x_o SHALL be k for a non-hazardous match. It SHALL be 0 with no match, with the source unused, or with a hazardous youngest match; an older stage SHALL never be forwarded past a hazardous younger one.
REQ-026 stall_o SHALL be 1 if either used source has a hazardous youngest match; all forward outputs and stall_o are combinational from the records and the ID inputs.
REQ-027 stall_o=1 SHALL persist until the load ages past stage LOAD_LAT; no other internal state is needed.
REQ-028 When LOAD_LAT=0, stall_o SHALL be constantly 0.
REQ-029 stall_cnt_o SHALL increment on each clock with stall_o=1, and fwd_cnt_o on each clock with either forward code nonzero; both SHALL saturate at 16'hFFFF without wrapping.
REQ-030 Source register 0 SHALL never match, because records with rd=0 are invalid.

Reset
REQ-031 rst_n_i=0 SHALL immediately clear every record's valid bit and both counters, independent of clk_i.
REQ-032 While in reset and on the first cycle after it, fwd_rs_o=fwd_rt_o=0 and stall_o=0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight records; no forward from a pre-reset issue SHALL appear after release.

Verification (DEPTH=2, LOAD_LAT=1)
REQ-034 Issue ALU rd=3 we=1, then issue bubbles; id_rs=3 used -> fwd_rs_o = 1, 2, 0 on the following three cycles; fwd_cnt_o=2.
REQ-035 Issue rd=5 on cycle 0 and rd=5 on cycle 1; cycle 2 id_rt=5 used -> fwd_rt_o=1 (youngest wins).
REQ-036 Issue load rd=4; next cycle id_rt=4 used -> stall_o=1, fwd_rt_o=0, stall_cnt_o 0->1; following cycle -> stall_o=0, fwd_rt_o=2.
REQ-037 Issue rd=0 we=1, or rd=6 with id_rs=6 and id_rs_used_i=0 -> fwd 0, stall 0; issue load rd=6 with id_rs_used_i=0 -> stall_o=0.
REQ-038 Issue rd=7 with flush_i=1 -> next cycle id_rs=7 -> fwd_rs_o=0; an older record rd=8 still yields fwd_rt_o=2.
REQ-039 Assert rst_n_i asynchronously with record 1 = load rd=4 and id_rs=4 -> stall_o falls immediately; after release fwd=0 and counters=0; drive stall for 70000 cycles -> stall_cnt_o holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection and operand forwarding for an in-order pipeline.
// A short shift pipeline remembers the destination of each in-flight writer.
// The ID-stage sources are matched against it, youngest writer first.
// A match on a load that is still too young to forward stalls the front end.
// Saturating counters report stall cycles and forwarding cycles.
module hazard_forward_unit #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    localparam int SW      = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              issue_valid_i,
    input  logic [REG_AW-1:0] issue_rd_i,
    input  logic              issue_we_i,
    input  logic              issue_load_i,
    input  logic              flush_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    output logic [SW-1:0]     fwd_rs_o,
    output logic [SW-1:0]     fwd_rt_o,
    output logic              stall_o,
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       fwd_cnt_o
);

    // Index gi of these arrays holds stage gi+1 (index 0 is the youngest).
    logic [DEPTH-1:0]  valid_reg;
    logic [REG_AW-1:0] rd_reg [DEPTH];
    logic [DEPTH-1:0]  load_reg;

    // Per-stage match and hazard flags.
    logic [DEPTH-1:0]  rs_hit;
    logic [DEPTH-1:0]  rt_hit;
    logic [DEPTH-1:0]  haz_stage;

    // Youngest-match selection results.
    logic [SW-1:0]     rs_code;
    logic [SW-1:0]     rt_code;
    logic              rs_haz;
    logic              rt_haz;
    logic              rs_stall;
    logic              rt_stall;

    // Counter next-state values.
    logic [15:0]       stall_cnt_reg;
    logic [15:0]       stall_cnt_next;
    logic [15:0]       fwd_cnt_reg;
    logic [15:0]       fwd_cnt_next;

    // An issue is only recorded when it really leaves ID. A stalled ID slot
    // becomes a bubble, and a flushed one never existed.
    logic              issue_take;
    logic              issue_writes;

    assign issue_take   = issue_valid_i && !flush_i && !stall_o;
    // Writes to register 0 are dropped here, so source 0 can never match.
    assign issue_writes = issue_take && issue_we_i && (issue_rd_i != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // Stage 1 captures the issuing instruction or a bubble.
                always_ff @(posedge clk_i or negedge rst_n_i) begin
                    if (!rst_n_i) begin
                        valid_reg[0] <= 1'b0;
                        rd_reg[0]    <= '0;
                        load_reg[0]  <= 1'b0;
                    end else begin
                        valid_reg[0] <= issue_writes;
                        rd_reg[0]    <= issue_rd_i;
                        load_reg[0]  <= issue_load_i;
                    end
                end
            end else begin : g_tail
                // Older stages simply age the record by one cycle.
                always_ff @(posedge clk_i or negedge rst_n_i) begin
                    if (!rst_n_i) begin
                        valid_reg[gi] <= 1'b0;
                        rd_reg[gi]    <= '0;
                        load_reg[gi]  <= 1'b0;
                    end else begin
                        valid_reg[gi] <= valid_reg[gi-1];
                        rd_reg[gi]    <= rd_reg[gi-1];
                        load_reg[gi]  <= load_reg[gi-1];
                    end
                end
            end

            assign rs_hit[gi] = valid_reg[gi] && (rd_reg[gi] == id_rs_i);
            assign rt_hit[gi] = valid_reg[gi] && (rd_reg[gi] == id_rt_i);

            // A load result is unavailable while it sits in stages 1..LOAD_LAT.
            assign haz_stage[gi] = load_reg[gi] && (gi < LOAD_LAT);
        end
    endgenerate

    // Pick the youngest matching stage for rs; scanning oldest-to-youngest
    // lets the youngest hit overwrite any older one.
    always_comb begin
        rs_code = '0;
        rs_haz  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rs_hit[k]) begin
                rs_code = SW'(k + 1);
                rs_haz  = haz_stage[k];
            end
        end
    end

    // Same youngest-match selection for rt.
    always_comb begin
        rt_code = '0;
        rt_haz  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rt_hit[k]) begin
                rt_code = SW'(k + 1);
                rt_haz  = haz_stage[k];
            end
        end
    end

    // A hazardous youngest match blocks forwarding from any older stage,
    // because the older value would be stale.
    assign rs_stall = id_rs_used_i && rs_haz;
    assign rt_stall = id_rt_used_i && rt_haz;
    assign fwd_rs_o = (id_rs_used_i && !rs_haz) ? rs_code : '0;
    assign fwd_rt_o = (id_rt_used_i && !rt_haz) ? rt_code : '0;
    assign stall_o  = rs_stall || rt_stall;

    // Saturating increments for both statistics counters.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        fwd_cnt_next   = fwd_cnt_reg;
        if (stall_o && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
        if (((fwd_rs_o != '0) || (fwd_rt_o != '0)) && (fwd_cnt_reg != 16'hFFFF)) begin
            fwd_cnt_next = fwd_cnt_reg + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_reg <= '0;
            fwd_cnt_reg   <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            fwd_cnt_reg   <= fwd_cnt_next;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
    assign fwd_cnt_o   = fwd_cnt_reg;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit. Three instances share one stimulus:
// m_ (DEPTH=2, LOAD_LAT=1), s_ (DEPTH=4, LOAD_LAT=3), z_ (DEPTH=2, LOAD_LAT=0).
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_we;
    logic        issue_load;
    logic        flush;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;

    logic [1:0]  m_fwd_rs, m_fwd_rt;
    logic        m_stall;
    logic [15:0] m_stall_cnt, m_fwd_cnt;
    logic [2:0]  s_fwd_rs, s_fwd_rt;
    logic        s_stall;
    logic [15:0] s_stall_cnt, s_fwd_cnt;
    logic [1:0]  z_fwd_rs, z_fwd_rt;
    logic        z_stall;
    logic [15:0] z_stall_cnt, z_fwd_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_AW(5), .DEPTH(2), .LOAD_LAT(1)) u_main (
        .clk_i(clk), .rst_n_i(rst_n),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_we_i(issue_we),
        .issue_load_i(issue_load), .flush_i(flush),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
        .fwd_rs_o(m_fwd_rs), .fwd_rt_o(m_fwd_rt), .stall_o(m_stall),
        .stall_cnt_o(m_stall_cnt), .fwd_cnt_o(m_fwd_cnt)
    );

    hazard_forward_unit #(.REG_AW(5), .DEPTH(4), .LOAD_LAT(3)) u_deep (
        .clk_i(clk), .rst_n_i(rst_n),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_we_i(issue_we),
        .issue_load_i(issue_load), .flush_i(flush),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
        .fwd_rs_o(s_fwd_rs), .fwd_rt_o(s_fwd_rt), .stall_o(s_stall),
        .stall_cnt_o(s_stall_cnt), .fwd_cnt_o(s_fwd_cnt)
    );

    hazard_forward_unit #(.REG_AW(5), .DEPTH(2), .LOAD_LAT(0)) u_zero (
        .clk_i(clk), .rst_n_i(rst_n),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_we_i(issue_we),
        .issue_load_i(issue_load), .flush_i(flush),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
        .fwd_rs_o(z_fwd_rs), .fwd_rt_o(z_fwd_rt), .stall_o(z_stall),
        .stall_cnt_o(z_stall_cnt), .fwd_cnt_o(z_fwd_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic v, input logic [4:0] rd, input logic we,
                               input logic ld, input logic fl);
        issue_valid = v;
        issue_rd    = rd;
        issue_we    = we;
        issue_load  = ld;
        flush       = fl;
        $display("txn t=%0t issue v=%0b rd=%0d we=%0b ld=%0b flush=%0b", $time, v, rd, we, ld, fl);
    endtask

    task automatic drive_id(input logic [4:0] rs, input logic rs_u,
                            input logic [4:0] rt, input logic rt_u);
        id_rs      = rs;
        id_rs_used = rs_u;
        id_rt      = rt;
        id_rt_used = rt_u;
        $display("txn t=%0t id rs=%0d/%0b rt=%0d/%0b", $time, rs, rs_u, rt, rt_u);
    endtask

    initial begin
        // Reset with a pending ALU issue of rd=3 and rs=3 in use.
        rst_n = 1'b0;
        drive_issue(1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        drive_id(5'd3, 1'b1, 5'd0, 1'b0);
        #8;
        check_val("rst_fwd_rs", m_fwd_rs, 0);
        check_val("rst_stall", m_stall, 0);
        check_val("rst_stall_cnt", m_stall_cnt, 0);
        check_val("rst_fwd_cnt", m_fwd_cnt, 0);
        #4 rst_n = 1'b1;
        #1;
        check_val("post_rst_fwd_rs", m_fwd_rs, 0);
        check_val("post_rst_stall", m_stall, 0);

        // ALU rd=3 ages through the pipe: 1, 2, then gone.
        step(); drive_issue(1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #2;
        check_val("alu_age1", m_fwd_rs, 1);
        step(); #2;
        check_val("alu_age2", m_fwd_rs, 2);
        step(); #2;
        check_val("alu_age3", m_fwd_rs, 0);
        check_val("alu_fwd_cnt", m_fwd_cnt, 2);

        // Two writers of rd=5: the youngest wins.
        drive_id(5'd0, 1'b0, 5'd0, 1'b0);
        drive_issue(1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        step(); drive_issue(1'b0, 5'd0, 1'b0, 1'b0, 1'b0); drive_id(5'd0, 1'b0, 5'd5, 1'b1); #2;
        check_val("youngest_rt", m_fwd_rt, 1);
        step(); #2;
        check_val("older_rt", m_fwd_rt, 2);

        // Load-use on rd=4; an issue during the stall must be dropped.
        step(); drive_id(5'd0, 1'b0, 5'd0, 1'b0); drive_issue(1'b1, 5'd4, 1'b1, 1'b1, 1'b0); #2;
        check_val("fwd_cnt_4", m_fwd_cnt, 4);
        step(); drive_issue(1'b1, 5'd9, 1'b1, 1'b0, 1'b0); drive_id(5'd0, 1'b0, 5'd4, 1'b1); #2;
        check_val("lu_stall", m_stall, 1);
        check_val("lu_fwd_rt", m_fwd_rt, 0);
        check_val("lu_stall_cnt0", m_stall_cnt, 0);
        check_val("deep_lu_stall", s_stall, 1);
        check_val("zero_lu_stall", z_stall, 0);
        check_val("zero_lu_fwd_rt", z_fwd_rt, 1);
        step(); drive_issue(1'b0, 5'd0, 1'b0, 1'b0, 1'b0); drive_id(5'd9, 1'b1, 5'd4, 1'b1); #2;
        check_val("lu_release_stall", m_stall, 0);
        check_val("lu_release_rt", m_fwd_rt, 2);
        check_val("stalled_issue_rs", m_fwd_rs, 0);
        check_val("lu_stall_cnt1", m_stall_cnt, 1);
        check_val("deep_lu_stage2", s_stall, 1);
        check_val("zero_issue_rs", z_fwd_rs, 1);
        check_val("zero_old_rt", z_fwd_rt, 2);

        // Register 0 and unused sources.
        step(); drive_id(5'd0, 1'b0, 5'd0, 1'b0); drive_issue(1'b1, 5'd0, 1'b1, 1'b0, 1'b0); #2;
        check_val("fwd_cnt_5", m_fwd_cnt, 5);
        step(); drive_id(5'd0, 1'b1, 5'd0, 1'b1); drive_issue(1'b1, 5'd6, 1'b1, 1'b0, 1'b0); #2;
        check_val("r0_fwd_rs", m_fwd_rs, 0);
        check_val("r0_fwd_rt", m_fwd_rt, 0);
        check_val("r0_stall", m_stall, 0);
        step(); drive_id(5'd6, 1'b0, 5'd6, 1'b1); drive_issue(1'b1, 5'd6, 1'b1, 1'b1, 1'b0); #2;
        check_val("unused_rs", m_fwd_rs, 0);
        check_val("used_rt", m_fwd_rt, 1);
        step(); drive_id(5'd6, 1'b0, 5'd0, 1'b0); drive_issue(1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #2;
        check_val("unused_load_stall", m_stall, 0);
        check_val("unused_load_rs", m_fwd_rs, 0);

        // Flush squashes rd=7 but leaves the older rd=8 in stage 2.
        step(); drive_id(5'd0, 1'b0, 5'd0, 1'b0); drive_issue(1'b1, 5'd8, 1'b1, 1'b0, 1'b0); #2;
        check_val("fwd_cnt_6", m_fwd_cnt, 6);
        step(); drive_issue(1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
        step(); drive_issue(1'b0, 5'd0, 1'b0, 1'b0, 1'b0); drive_id(5'd7, 1'b1, 5'd8, 1'b1); #2;
        check_val("flush_rs", m_fwd_rs, 0);
        check_val("flush_old_rt", m_fwd_rt, 2);

        // Asynchronous reset mid-stall drops everything at once.
        step(); drive_id(5'd0, 1'b0, 5'd0, 1'b0); drive_issue(1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
        step(); drive_issue(1'b0, 5'd0, 1'b0, 1'b0, 1'b0); drive_id(5'd4, 1'b1, 5'd0, 1'b0); #2;
        check_val("pre_arst_stall", m_stall, 1);
        #1 rst_n = 1'b0;
        #1;
        check_val("arst_stall", m_stall, 0);
        check_val("arst_stall_cnt", m_stall_cnt, 0);
        check_val("arst_fwd_cnt", m_fwd_cnt, 0);
        #1 rst_n = 1'b1;
        step();
        check_val("after_arst_rs", m_fwd_rs, 0);
        check_val("after_arst_stall", m_stall, 0);
        check_val("after_arst_stall_cnt", m_stall_cnt, 0);

        // Back-to-back loads of rd=4 with rs=4 in use, long enough to saturate.
        #2 rst_n = 1'b0;
        drive_issue(1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
        drive_id(5'd4, 1'b1, 5'd0, 1'b0);
        #2 rst_n = 1'b1;
        for (int c = 1; c <= 87400; c++) begin
            @(posedge clk);
            #1;
            if (c == 1000) begin
                check_val("run_m_stall_cnt", m_stall_cnt, 500);
                check_val("run_m_fwd_cnt", m_fwd_cnt, 499);
                check_val("run_s_stall_cnt", s_stall_cnt, 750);
                check_val("run_z_fwd_cnt", z_fwd_cnt, 999);
                check_val("run_z_stall_cnt", z_stall_cnt, 0);
            end
            if (c == 65535) check_val("z_fwd_cnt_presat", z_fwd_cnt, 65534);
            if (c == 87379) check_val("s_stall_cnt_presat", s_stall_cnt, 65534);
            if (c == 87400) begin
                check_val("s_stall_cnt_sat", s_stall_cnt, 16'hFFFF);
                check_val("z_fwd_cnt_sat", z_fwd_cnt, 16'hFFFF);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
